pkt_parser: RTL and testbench
=============================

Name: pkt_parser

Overview:
Parametrised successor to the fixed 8-byte packet handler. It hunts a start-of-frame byte in the rx byte stream and assembles a frame of configurable payload width. It validates an XOR checksum, filters on vehicle/previous-vehicle ID, and detects kill frames. An inter-byte timeout resynchronises the parser, and the decoded payload is presented on a valid/ready output with backpressure into the rx interface.

Parameters:
DATA_W, 16, payload width in bits; multiple of 8, 8..64. Derived: PAY_BYTES = DATA_W/8, FRAME_BYTES = PAY_BYTES + 4.
TIMEOUT, 255, idle cycles allowed between accepted bytes inside a frame; range 1..65535.
MATCH_PREV, 1, 1 = prev_id must match; 0 = only veh_id checked.
ERR_W, 16, width of saturating error counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
veh_id  in  8  own vehicle ID
prev_id  in  8  expected preceding-vehicle ID
rx_byte  in  8  incoming byte
rx_valid  in  1  rx_byte valid
rx_ready  out  1  parser accepts byte this cycle
data  out  DATA_W  payload, big-endian (first payload byte = MSBs)
data_valid  out  1  data/kill valid, held until data_ready
data_ready  in  1  downstream accepts
kill  out  1  kill frame flag, meaningful only with data_valid
frame_drop  out  1  1-cycle pulse on checksum error or timeout
err_cnt  out  ERR_W  saturating count of frame_drop events

Behaviour:
- Frame layout, byte 0 first: 0xA5 SOF; veh_id; prev_id; PAY_BYTES payload, MSB first; checksum = XOR of bytes 1..FRAME_BYTES-2.
- Byte accepted iff rx_valid && rx_ready.
- rx_ready = 1 in IDLE and COLLECT, 0 in HOLD.
- IDLE: non-0xA5 bytes consumed and discarded. 0xA5 -> COLLECT, byte index = 1, checksum accumulator = 0.
- COLLECT: each accepted byte is stored at its index and XORed into the accumulator (except the checksum byte). Idle-cycle counter resets on every accept. 0xA5 inside COLLECT is ordinary data; there is no resync.
- Timeout: idle counter reaching TIMEOUT in COLLECT -> frame_drop pulse, err_cnt++, go to IDLE. Partial frame discarded.
- Last byte accepted in cycle T: verdict registered at T+1.
  - Checksum mismatch -> frame_drop at T+1, err_cnt++, IDLE.
  - Kill frame (bytes 1..FRAME_BYTES-2 all 0xFF, checksum OK) -> HOLD with kill=1, data=all ones; ID filter bypassed.
  - ID match (veh_id, plus prev_id if MATCH_PREV) -> HOLD with kill=0.
  - ID mismatch -> silent discard to IDLE; not an error.
- HOLD: data_valid=1 from T+1. data and kill stable until the cycle with data_ready=1, then -> IDLE next cycle. data_ready=1 constantly gives exactly one data_valid cycle per frame.
- err_cnt saturates at all ones. Checksum error and timeout cannot coincide.
- Reset, including mid-frame: state IDLE, rx_ready=1, data=0, data_valid=0, kill=0, frame_drop=0, err_cnt=0, idle counter 0. Partial frame lost.
- veh_id/prev_id sampled at verdict cycle; they must be static during a frame.

Decomposition:
- Package pkt_pkg: SOF constant 0xA5, state enum {IDLE, COLLECT, HOLD}, helper for FRAME_BYTES from DATA_W.
- One sub-module: pkt_timeout, a TIMEOUT-parametrised idle counter with clear/enable/expire.
- Checksum accumulator and frame register stay inline.

Test Plan:
- DATA_W=16, veh_id=0x12, prev_id=0x11; bytes 00 A5 12 11 BE EF 52, rx_valid continuous, data_ready=1 -> 00 discarded; data_valid=1 for exactly one cycle, one clock after 0x52 accepted; data=0xBEEF, kill=0, err_cnt=0.
- Bytes A5 FF FF FF FF 00, local IDs 0x12/0x11 -> data_valid=1, kill=1, data=0xFFFF.
- Bytes A5 12 11 BE EF 53 -> no data_valid, frame_drop single pulse, err_cnt=1. Repeated with err_cnt forced near max -> saturates at 0xFFFF.
- TIMEOUT=4: A5 12 then rx_valid=0 for 4 cycles -> frame_drop, err_cnt=1. Following good frame decodes to 0xBEEF.
- Good frame with data_ready=0 for 5 cycles -> data_valid and data=0xBEEF held 6 cycles, rx_ready=0 throughout. Next frame accepted after handshake.
- rst_n low after byte 3; then full good frame -> outputs at reset values during reset; afterwards one clean decode 0xBEEF. Also prev_id=0x22 with MATCH_PREV=1 -> discarded, with MATCH_PREV=0 -> decoded.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet parser.
//   SofByte     : start-of-frame marker
//   state_e     : parser FSM states
//   frame_bytes : total frame length (SOF + veh + prev + payload + checksum)
package pkt_pkg;

  localparam logic [7:0] SofByte = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } state_e;

  function automatic int unsigned frame_bytes(input int unsigned data_w);
    return data_w / 8 + 4;
  endfunction

endpackage

// File: rtl/pkt_timeout.sv
// Inter-byte idle counter.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (byte accepted or not collecting)
//   enable     : an idle cycle inside a frame
//   expire     : this idle cycle is the TIMEOUT-th one in a row
module pkt_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // Fires on the idle cycle that would bring the count to TIMEOUT.
  assign expire = enable && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_parser.sv
// Byte-stream frame parser: hunts SOF, assembles a frame, checks the XOR checksum,
// filters on vehicle IDs, flags kill frames and presents the payload on valid/ready.
//   clk, rst_n        : clock, async active-low reset
//   veh_id, prev_id   : local IDs, static during a frame
//   rx_byte/valid/ready : input byte stream
//   data, kill, data_valid, data_ready : decoded output with backpressure
//   frame_drop        : 1-cycle pulse on checksum error or inter-byte timeout
//   err_cnt           : saturating count of frame_drop events
module pkt_parser
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          MATCH_PREV = 1'b1,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        veh_id,
  input  logic [7:0]        prev_id,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              kill,
  output logic              frame_drop,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned FrameBytes = frame_bytes(DATA_W);
  localparam int unsigned IdxW       = $clog2(FrameBytes);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [7:0]        acc_q;
  logic              all_ff_q;
  logic [7:0]        veh_q;
  logic [7:0]        prev_q;
  logic [DATA_W-1:0] pay_q;
  logic [DATA_W-1:0] data_q;
  logic              kill_q;
  logic              data_valid_q;
  logic              frame_drop_q;
  logic [ERR_W-1:0]  err_q;

  logic              accept;
  logic              in_collect;
  logic              last_byte;
  logic              csum_ok;
  logic              id_ok;
  logic              to_expire;
  logic              drop_evt;
  logic [DATA_W-1:0] pay_shift;

  assign rx_ready   = (state_q != StHold);
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign kill       = kill_q;
  assign frame_drop = frame_drop_q;
  assign err_cnt    = err_q;

  always_comb begin
    accept     = rx_valid && rx_ready;
    in_collect = (state_q == StCollect);
    last_byte  = in_collect && accept && (idx_q == IdxW'(FrameBytes - 1));
    csum_ok    = (acc_q == rx_byte);
    id_ok      = (veh_q == veh_id) && (!MATCH_PREV || (prev_q == prev_id));
    // Payload arrives MSB first: shift left, new byte into the low end.
    pay_shift  = DATA_W'({pay_q, rx_byte});
    drop_evt   = (last_byte && !csum_ok) || to_expire;
  end

  pkt_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!in_collect || accept),
    .enable(in_collect && !accept),
    .expire(to_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      acc_q        <= '0;
      all_ff_q     <= 1'b0;
      veh_q        <= '0;
      prev_q       <= '0;
      pay_q        <= '0;
      data_q       <= '0;
      kill_q       <= 1'b0;
      data_valid_q <= 1'b0;
      frame_drop_q <= 1'b0;
      err_q        <= '0;
    end else begin
      frame_drop_q <= drop_evt;
      if (drop_evt && (err_q != {ERR_W{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (accept && (rx_byte == SofByte)) begin
            state_q  <= StCollect;
            idx_q    <= IdxW'(1);
            acc_q    <= '0;
            all_ff_q <= 1'b1;
          end
        end

        StCollect: begin
          if (to_expire) begin
            state_q <= StIdle;
          end else if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (last_byte) begin
              if (!csum_ok) begin
                state_q <= StIdle;
              end else if (all_ff_q) begin
                // Kill frames bypass the ID filter.
                state_q      <= StHold;
                data_valid_q <= 1'b1;
                kill_q       <= 1'b1;
                data_q       <= '1;
              end else if (id_ok) begin
                state_q      <= StHold;
                data_valid_q <= 1'b1;
                kill_q       <= 1'b0;
                data_q       <= pay_q;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              acc_q    <= acc_q ^ rx_byte;
              all_ff_q <= all_ff_q && (rx_byte == 8'hFF);
              if (idx_q == IdxW'(1)) begin
                veh_q <= rx_byte;
              end else if (idx_q == IdxW'(2)) begin
                prev_q <= rx_byte;
              end else begin
                pay_q <= pay_shift;
              end
            end
          end
        end

        StHold: begin
          if (data_ready) begin
            state_q      <= StIdle;
            data_valid_q <= 1'b0;
            kill_q       <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_parser.sv
// Bench for pkt_parser. Instance a: TIMEOUT=4, MATCH_PREV=1, ERR_W=16.
// Instance b: TIMEOUT=4, MATCH_PREV=0, ERR_W=2 (small counter to reach saturation).
module tb_pkt_parser;

  localparam logic [1:0] KNone = 2'd0;
  localparam logic [1:0] KData = 2'd1;
  localparam logic [1:0] KDrop = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        kill;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] bytes;  // left-justified, first byte in [63:56]
    int          len;
    logic [7:0]  prev;
    logic [1:0]  ka;
    logic [1:0]  kb;
    logic        kill;
    logic [15:0] data;
    int          stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  veh_id, prev_id, rx_byte;
  logic        rx_valid, data_ready;

  logic        a_rx_ready, a_dv, a_kill, a_fd;
  logic [15:0] a_data, a_err;
  logic        b_rx_ready, b_dv, b_kill, b_fd;
  logic [15:0] b_data;
  logic [1:0]  b_err;

  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] erra;
  logic [1:0]  errb;
  vec_t vecs[10];

  always #5 clk = ~clk;

  pkt_parser #(.DATA_W(16), .TIMEOUT(4), .MATCH_PREV(1'b1), .ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .veh_id(veh_id), .prev_id(prev_id), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(a_rx_ready), .data(a_data), .data_valid(a_dv),
    .data_ready(data_ready), .kill(a_kill), .frame_drop(a_fd), .err_cnt(a_err)
  );

  pkt_parser #(.DATA_W(16), .TIMEOUT(4), .MATCH_PREV(1'b0), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .veh_id(veh_id), .prev_id(prev_id), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(b_rx_ready), .data(b_data), .data_valid(b_dv),
    .data_ready(data_ready), .kill(b_kill), .frame_drop(b_fd), .err_cnt(b_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input int got, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic vec_t mk(input logic [63:0] bytes, input int len, input logic [7:0] prev,
                              input logic [1:0] ka, input logic [1:0] kb, input logic kill,
                              input logic [15:0] data, input int stall);
    vec_t v;
    v.bytes = bytes; v.len = len; v.prev = prev; v.ka = ka; v.kb = kb;
    v.kill = kill; v.data = data; v.stall = stall;
    return v;
  endfunction

  // Scoreboards: every output handshake or drop pulse must match the next expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (a_dv && data_ready) begin
        if (qa.size() == 0) fail("a_unexpected_data", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_kind_data", 32'(KData), 32'(e.kind));
          check("a_data", a_data, e.data);
          check("a_kill", a_kill, e.kill);
        end
      end
      if (a_fd) begin
        if (qa.size() == 0) fail("a_unexpected_drop", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_kind_drop", 32'(KDrop), 32'(e.kind));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (b_dv && data_ready) begin
        if (qb.size() == 0) fail("b_unexpected_data", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_kind_data", 32'(KData), 32'(e.kind));
          check("b_data", b_data, e.data);
          check("b_kill", b_kill, e.kill);
        end
      end
      if (b_fd) begin
        if (qb.size() == 0) fail("b_unexpected_drop", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_kind_drop", 32'(KDrop), 32'(e.kind));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int len);
    for (int i = 0; i < len; i++) begin
      int t;
      rx_byte  = bytes[63-8*i -: 8];
      rx_valid = 1'b1;
      t = 0;
      while (!(a_rx_ready && b_rx_ready) && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) fail("rx_ready_wait", 0, 1);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    data_ready = 1'b1;
    t = 0;
    while (!(a_rx_ready && b_rx_ready) && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) fail("drain_wait", 0, 1);
    tick();
  endtask

  task automatic bump_err(input logic [1:0] ka, input logic [1:0] kb);
    if (ka == KDrop && erra != 16'hFFFF) erra = erra + 16'd1;
    if (kb == KDrop && errb != 2'b11) errb = errb + 2'd1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    prev_id    = v.prev;
    data_ready = (v.stall == 0);
    e.kill = v.kill;
    e.data = v.data;
    if (v.ka != KNone) begin e.kind = v.ka; qa.push_back(e); end
    if (v.kb != KNone) begin e.kind = v.kb; qb.push_back(e); end
    send_frame(v.bytes, v.len);
    bump_err(v.ka, v.kb);
    // First cycle after the last byte: verdict visible.
    check("dv_a", a_dv, v.ka == KData);
    check("fd_a", a_fd, v.ka == KDrop);
    check("dv_b", b_dv, v.kb == KData);
    check("fd_b", b_fd, v.kb == KDrop);
    check("err_a", a_err, erra);
    check("err_b", b_err, errb);
    if (v.stall == 0) begin
      tick();
      check("dv_a_once", a_dv, 0);
      check("dv_b_once", b_dv, 0);
      check("fd_a_once", a_fd, 0);
    end else begin
      for (int k = 0; k < v.stall; k++) begin
        check("hold_dv", a_dv, 1);
        check("hold_data", a_data, v.data);
        check("hold_rx_ready", a_rx_ready, 0);
        tick();
      end
      check("hold_last_dv", a_dv, 1);
      check("hold_last_data", a_data, v.data);
      data_ready = 1'b1;
      tick();
      check("after_hs_dv", a_dv, 0);
      check("after_hs_rx_ready", a_rx_ready, 1);
    end
    drain();
  endtask

  initial begin
    vecs[0] = mk(64'h00A5_1211_BEEF_5200, 7, 8'h11, KData, KData, 1'b0, 16'hBEEF, 0);
    vecs[1] = mk(64'hA5FF_FFFF_FF00_0000, 6, 8'h11, KData, KData, 1'b1, 16'hFFFF, 0);
    vecs[2] = mk(64'hA512_11BE_EF53_0000, 6, 8'h11, KDrop, KDrop, 1'b0, 16'h0000, 0);
    vecs[3] = mk(64'hA512_11BE_EF52_0000, 6, 8'h22, KNone, KData, 1'b0, 16'hBEEF, 0);
    vecs[4] = mk(64'hA512_1101_0200_0000, 6, 8'h11, KData, KData, 1'b0, 16'h0102, 0);
    vecs[5] = mk(64'hA513_11BE_EF53_0000, 6, 8'h11, KNone, KNone, 1'b0, 16'h0000, 0);
    vecs[6] = mk(64'hA512_11A5_A503_0000, 6, 8'h11, KData, KData, 1'b0, 16'hA5A5, 0);
    vecs[7] = mk(64'hFFFF_A5FF_FFFF_FF01, 8, 8'h11, KDrop, KDrop, 1'b0, 16'h0000, 0);
    vecs[8] = mk(64'hA512_11BE_EF52_0000, 6, 8'h11, KData, KData, 1'b0, 16'hBEEF, 5);
    vecs[9] = mk(64'hA512_1101_0207_0000, 6, 8'h11, KDrop, KDrop, 1'b0, 16'h0000, 0);

    rst_n = 1'b0; veh_id = 8'h12; prev_id = 8'h11; rx_byte = 8'h00;
    rx_valid = 1'b0; data_ready = 1'b1;
    erra = '0; errb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", a_rx_ready, 1);
    check("rst_dv", a_dv, 0);
    check("rst_kill", a_kill, 0);
    check("rst_fd", a_fd, 0);
    check("rst_data", a_data, 0);
    check("rst_err", a_err, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Inter-byte timeout: four idle cycles after 0x12, drop visible on the fifth.
    prev_id = 8'h11;
    begin
      exp_t e;
      e.kind = KDrop; e.kill = 1'b0; e.data = 16'h0000;
      qa.push_back(e);
      qb.push_back(e);
    end
    send_frame(64'hA512_0000_0000_0000, 2);
    for (int k = 0; k < 4; k++) begin
      check("to_early_fd", a_fd, 0);
      tick();
    end
    bump_err(KDrop, KDrop);
    check("to_fd_a", a_fd, 1);
    check("to_fd_b", b_fd, 1);
    check("to_err_a", a_err, erra);
    check("to_err_b_sat", b_err, errb);
    tick();
    check("to_fd_pulse", a_fd, 0);
    drain();
    run_vec(vecs[0]);

    // Reset in the middle of a frame.
    send_frame(64'hA512_1100_0000_0000, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_ready", a_rx_ready, 1);
    check("mid_rst_dv", a_dv, 0);
    check("mid_rst_kill", a_kill, 0);
    check("mid_rst_fd", a_fd, 0);
    check("mid_rst_data", a_data, 0);
    check("mid_rst_err_a", a_err, 0);
    check("mid_rst_err_b", b_err, 0);
    erra = '0; errb = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    repeat (3) tick();
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
